dijkstra_ci_initiator: RTL and testbench

Hardware initiator for the Nios II custom-instruction protocol served by the Dijkstra accelerator interface. It accepts a stream of commands, each carrying a select code and two operands. For each command it issues one custom-instruction transaction, holds the operands until the responder raises `ready`, and returns the result on a response port. The block lets a DMA engine or a test sequencer drive the accelerator directly (edge-cache reset, edge writes, compute, reads) without the CPU. A watchdog recovers the responder if it hangs.

---
 rtl/dijkstra_ci_initiator.sv | 138 +++++++++++++
 tb/tb_dijkstra_ci_initiator.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dijkstra_ci_initiator.sv
// Custom-instruction initiator: takes one command at a time, runs a single
// start/ready handshake with the Dijkstra responder, and returns the result.
module dijkstra_ci_initiator #(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [7:0]             cmd_select_n,
    input  logic [31:0]            cmd_dataa,
    input  logic [31:0]            cmd_datab,
    output logic                   ci_start,
    output logic                   ci_reset,
    output logic [7:0]             ci_select_n,
    output logic [31:0]            ci_dataa,
    output logic [31:0]            ci_datab,
    input  logic [31:0]            ci_result,
    input  logic                   ci_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            rsp_result,
    output logic [7:0]             rsp_select_n,
    output logic                   rsp_timeout,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] txn_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ABORT,
        S_RESPOND
    } state_t;

    localparam logic [19:0] TIMER_LAST = 20'(TIMEOUT_CYCLES - 1);

    state_t                 r_state;
    logic [19:0]            r_timer;
    logic                   r_cmdReady;
    logic                   r_ciStart;
    logic                   r_abort;
    logic                   r_busy;
    logic                   r_rspValid;
    logic [7:0]             r_ciSelectN;
    logic [31:0]            r_ciDataa;
    logic [31:0]            r_ciDatab;
    logic [31:0]            r_rspResult;
    logic                   r_rspTimeout;
    logic [COUNT_WIDTH-1:0] r_txnCount;

    // All outputs are registered here and change together with the state they describe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_cmdReady   <= 1'b1;
            r_ciStart    <= 1'b0;
            r_abort      <= 1'b0;
            r_busy       <= 1'b0;
            r_rspValid   <= 1'b0;
            r_ciSelectN  <= '0;
            r_ciDataa    <= '0;
            r_ciDatab    <= '0;
            r_rspResult  <= '0;
            r_rspTimeout <= 1'b0;
            r_txnCount   <= '0;
        end else begin
            r_ciStart <= 1'b0;
            r_abort   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_ciSelectN <= cmd_select_n;
                        r_ciDataa   <= cmd_dataa;
                        r_ciDatab   <= cmd_datab;
                        r_cmdReady  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_ciStart   <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_timer <= r_timer + 20'd1;
                    // A completion in the expiry cycle still counts as success.
                    if (ci_ready) begin
                        r_rspResult  <= ci_result;
                        r_rspTimeout <= 1'b0;
                        r_rspValid   <= 1'b1;
                        r_state      <= S_RESPOND;
                    end else if (r_timer == TIMER_LAST) begin
                        r_abort <= 1'b1;
                        r_state <= S_ABORT;
                    end
                end
                S_ABORT: begin
                    r_rspResult  <= 32'hdeadbeef;
                    r_rspTimeout <= 1'b1;
                    r_rspValid   <= 1'b1;
                    r_state      <= S_RESPOND;
                end
                S_RESPOND: begin
                    if (rsp_ready) begin
                        r_txnCount <= r_txnCount + COUNT_WIDTH'(1);
                        r_rspValid <= 1'b0;
                        r_cmdReady <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Master reset reaches the responder without waiting for a clock edge.
    assign ci_reset     = reset | r_abort;
    assign cmd_ready    = r_cmdReady;
    assign ci_start     = r_ciStart;
    assign ci_select_n  = r_ciSelectN;
    assign ci_dataa     = r_ciDataa;
    assign ci_datab     = r_ciDatab;
    assign rsp_valid    = r_rspValid;
    assign rsp_result   = r_rspResult;
    assign rsp_select_n = r_ciSelectN;
    assign rsp_timeout  = r_rspTimeout;
    assign busy         = r_busy;
    assign txn_count    = r_txnCount;

endmodule

// File: tb/tb_dijkstra_ci_initiator.sv
// Directed bench for dijkstra_ci_initiator: dutA uses the default watchdog,
// dutB a short one (8 cycles) for the timeout and expiry-race scenarios.
module tb_dijkstra_ci_initiator;

    logic        clock;
    logic        reset;
    logic        cmdValidA, cmdValidB;
    logic [7:0]  cmdSelectN;
    logic [31:0] cmdDataa, cmdDatab;
    logic [31:0] ciResult;
    logic        ciReady;
    logic        rspReadyA, rspReadyB;

    logic        aCmdReady, aCiStart, aCiReset, aRspValid, aRspTimeout, aBusy;
    logic [7:0]  aCiSelectN, aRspSelectN;
    logic [31:0] aCiDataa, aCiDatab, aRspResult;
    logic [15:0] aTxnCount;

    logic        bCmdReady, bCiStart, bCiReset, bRspValid, bRspTimeout, bBusy;
    logic [7:0]  bCiSelectN, bRspSelectN;
    logic [31:0] bCiDataa, bCiDatab, bRspResult;
    logic [15:0] bTxnCount;

    int checks = 0;
    int errors = 0;

    dijkstra_ci_initiator dutA (
        .clock(clock), .reset(reset),
        .cmd_valid(cmdValidA), .cmd_ready(aCmdReady),
        .cmd_select_n(cmdSelectN), .cmd_dataa(cmdDataa), .cmd_datab(cmdDatab),
        .ci_start(aCiStart), .ci_reset(aCiReset), .ci_select_n(aCiSelectN),
        .ci_dataa(aCiDataa), .ci_datab(aCiDatab),
        .ci_result(ciResult), .ci_ready(ciReady),
        .rsp_valid(aRspValid), .rsp_ready(rspReadyA), .rsp_result(aRspResult),
        .rsp_select_n(aRspSelectN), .rsp_timeout(aRspTimeout),
        .busy(aBusy), .txn_count(aTxnCount)
    );

    dijkstra_ci_initiator #(.TIMEOUT_CYCLES(8), .COUNT_WIDTH(16)) dutB (
        .clock(clock), .reset(reset),
        .cmd_valid(cmdValidB), .cmd_ready(bCmdReady),
        .cmd_select_n(cmdSelectN), .cmd_dataa(cmdDataa), .cmd_datab(cmdDatab),
        .ci_start(bCiStart), .ci_reset(bCiReset), .ci_select_n(bCiSelectN),
        .ci_dataa(bCiDataa), .ci_datab(bCiDatab),
        .ci_result(ciResult), .ci_ready(ciReady),
        .rsp_valid(bRspValid), .rsp_ready(rspReadyB), .rsp_result(bRspResult),
        .rsp_select_n(bRspSelectN), .rsp_timeout(bRspTimeout),
        .busy(bBusy), .txn_count(bTxnCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset;
        @(negedge clock);
        @(negedge clock);
        checks++; if (aCiReset !== 1'b1) begin errors++; $display("[TB] FAIL rst_ci_reset_held got %b want 1", aCiReset); end
        checks++; if ({aCiStart, aRspValid, aBusy, aRspTimeout} !== 4'b0000) begin errors++; $display("[TB] FAIL rst_flags got %b want 0000", {aCiStart, aRspValid, aBusy, aRspTimeout}); end
        checks++; if ({aCiSelectN, aCiDataa, aCiDatab} !== 72'd0) begin errors++; $display("[TB] FAIL rst_ci_regs got %h want 0", {aCiSelectN, aCiDataa, aCiDatab}); end
        checks++; if ({aRspResult, aRspSelectN, aTxnCount} !== 56'd0) begin errors++; $display("[TB] FAIL rst_rsp_regs got %h want 0", {aRspResult, aRspSelectN, aTxnCount}); end
        checks++; if (bCiReset !== 1'b1) begin errors++; $display("[TB] FAIL rst_b_ci_reset got %b want 1", bCiReset); end
        reset = 1'b0;
        #1;
        checks++; if (aCiReset !== 1'b0) begin errors++; $display("[TB] FAIL rst_ci_reset_release got %b want 0", aCiReset); end
        checks++; if (aCmdReady !== 1'b1) begin errors++; $display("[TB] FAIL rst_cmd_ready got %b want 1", aCmdReady); end
    endtask

    task automatic test_single;
        @(negedge clock);
        checks++; if (aCmdReady !== 1'b1) begin errors++; $display("[TB] FAIL t1_cmd_ready got %b want 1", aCmdReady); end
        cmdValidA = 1'b1; cmdSelectN = 8'd1; cmdDataa = 32'd5; cmdDatab = 32'd0;
        @(negedge clock);
        cmdValidA = 1'b0;
        checks++; if (aCiStart !== 1'b1) begin errors++; $display("[TB] FAIL t1_start_t1 got %b want 1", aCiStart); end
        checks++; if ({aCiSelectN, aCiDataa} !== {8'd1, 32'd5}) begin errors++; $display("[TB] FAIL t1_latch got %h want %h", {aCiSelectN, aCiDataa}, {8'd1, 32'd5}); end
        @(negedge clock);
        checks++; if ({aCiStart, aRspValid} !== 2'b00) begin errors++; $display("[TB] FAIL t1_t2_flags got %b want 00", {aCiStart, aRspValid}); end
        ciReady = 1'b1; ciResult = 32'd0;
        @(negedge clock);
        checks++; if (aRspValid !== 1'b1) begin errors++; $display("[TB] FAIL t1_rsp_valid_t3 got %b want 1", aRspValid); end
        checks++; if ({aRspResult, aRspSelectN, aRspTimeout} !== {32'd0, 8'd1, 1'b0}) begin errors++; $display("[TB] FAIL t1_rsp got %h want %h", {aRspResult, aRspSelectN, aRspTimeout}, {32'd0, 8'd1, 1'b0}); end
        ciReady = 1'b0; rspReadyA = 1'b1;
        @(negedge clock);
        rspReadyA = 1'b0;
        checks++; if ({aRspValid, aCmdReady} !== 2'b01) begin errors++; $display("[TB] FAIL t1_after_rsp got %b want 01", {aRspValid, aCmdReady}); end
        checks++; if (aTxnCount !== 16'd1) begin errors++; $display("[TB] FAIL t1_txn_count got %0d want 1", aTxnCount); end
    endtask

    task automatic test_wait_hold;
        @(negedge clock);
        cmdValidA = 1'b1; cmdSelectN = 8'd0; cmdDataa = 32'h0003_0002; cmdDatab = 32'd7;
        ciResult = 32'hbad0_bad0;
        @(negedge clock);
        cmdValidA = 1'b0; cmdDataa = 32'hffff_ffff; cmdDatab = 32'hffff_ffff;
        checks++; if (aCiStart !== 1'b1) begin errors++; $display("[TB] FAIL t2_start got %b want 1", aCiStart); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checks++;
            if ({aCiStart, aRspValid, aCiDataa, aCiDatab} !== {2'b00, 32'h0003_0002, 32'd7}) begin
                errors++;
                $display("[TB] FAIL t2_hold_cycle%0d got %h want %h", i, {aCiStart, aRspValid, aCiDataa, aCiDatab}, {2'b00, 32'h0003_0002, 32'd7});
            end
        end
        @(negedge clock);
        checks++; if (aRspValid !== 1'b0) begin errors++; $display("[TB] FAIL t2_rsp_early got %b want 0", aRspValid); end
        ciReady = 1'b1; ciResult = 32'h0000_beef;
        @(negedge clock);
        ciReady = 1'b0;
        checks++; if (aRspValid !== 1'b1) begin errors++; $display("[TB] FAIL t2_rsp_valid_t13 got %b want 1", aRspValid); end
        checks++; if ({aRspResult, aRspSelectN, aRspTimeout} !== {32'h0000_beef, 8'd0, 1'b0}) begin errors++; $display("[TB] FAIL t2_rsp got %h want %h", {aRspResult, aRspSelectN, aRspTimeout}, {32'h0000_beef, 8'd0, 1'b0}); end
        rspReadyA = 1'b1;
        @(negedge clock);
        rspReadyA = 1'b0;
        checks++; if (aTxnCount !== 16'd2) begin errors++; $display("[TB] FAIL t2_txn_count got %0d want 2", aTxnCount); end
    endtask

    task automatic test_timeout;
        @(negedge clock);
        checks++; if (bCmdReady !== 1'b1) begin errors++; $display("[TB] FAIL t3_cmd_ready got %b want 1", bCmdReady); end
        cmdValidB = 1'b1; cmdSelectN = 8'd2; cmdDataa = 32'd1; cmdDatab = 32'd2;
        ciReady = 1'b0; ciResult = 32'h1111_1111;
        @(negedge clock);
        cmdValidB = 1'b0;
        checks++; if (bCiStart !== 1'b1) begin errors++; $display("[TB] FAIL t3_start got %b want 1", bCiStart); end
        for (int k = 2; k <= 9; k++) begin
            @(negedge clock);
            checks++;
            if ({bCiReset, bRspValid} !== 2'b00) begin errors++; $display("[TB] FAIL t3_wait_T%0d got %b want 00", k, {bCiReset, bRspValid}); end
        end
        @(negedge clock);
        checks++; if ({bCiReset, bRspValid} !== 2'b10) begin errors++; $display("[TB] FAIL t3_abort_T10 got %b want 10", {bCiReset, bRspValid}); end
        @(negedge clock);
        checks++; if ({bCiReset, bRspValid} !== 2'b01) begin errors++; $display("[TB] FAIL t3_respond_T11 got %b want 01", {bCiReset, bRspValid}); end
        checks++; if ({bRspResult, bRspSelectN, bRspTimeout} !== {32'hdeadbeef, 8'd2, 1'b1}) begin errors++; $display("[TB] FAIL t3_rsp got %h want %h", {bRspResult, bRspSelectN, bRspTimeout}, {32'hdeadbeef, 8'd2, 1'b1}); end
        rspReadyB = 1'b1;
        @(negedge clock);
        rspReadyB = 1'b0;
        checks++; if ({bCmdReady, bTxnCount} !== {1'b1, 16'd1}) begin errors++; $display("[TB] FAIL t3_after_rsp got %h want %h", {bCmdReady, bTxnCount}, {1'b1, 16'd1}); end
    endtask

    task automatic test_ready_at_expiry;
        @(negedge clock);
        cmdValidB = 1'b1; cmdSelectN = 8'd2; cmdDataa = 32'd3; cmdDatab = 32'd4;
        ciReady = 1'b0; ciResult = 32'h2222_2222;
        @(negedge clock);
        cmdValidB = 1'b0;
        for (int k = 2; k <= 8; k++) begin
            @(negedge clock);
            checks++;
            if ({bCiReset, bRspValid} !== 2'b00) begin errors++; $display("[TB] FAIL t4_wait_T%0d got %b want 00", k, {bCiReset, bRspValid}); end
        end
        @(negedge clock);
        checks++; if (bCiReset !== 1'b0) begin errors++; $display("[TB] FAIL t4_reset_T9 got %b want 0", bCiReset); end
        ciReady = 1'b1; ciResult = 32'h00c0_ffee;
        @(negedge clock);
        ciReady = 1'b0;
        checks++; if ({bCiReset, bRspValid, bRspTimeout} !== 3'b010) begin errors++; $display("[TB] FAIL t4_respond_T10 got %b want 010", {bCiReset, bRspValid, bRspTimeout}); end
        checks++; if (bRspResult !== 32'h00c0_ffee) begin errors++; $display("[TB] FAIL t4_rsp_result got %h want 00c0ffee", bRspResult); end
        rspReadyB = 1'b1;
        @(negedge clock);
        rspReadyB = 1'b0;
        checks++; if ({bCiReset, bTxnCount} !== {1'b0, 16'd2}) begin errors++; $display("[TB] FAIL t4_after_rsp got %h want %h", {bCiReset, bTxnCount}, {1'b0, 16'd2}); end
    endtask

    task automatic test_held_response;
        @(negedge clock);
        cmdValidA = 1'b1; cmdSelectN = 8'd3; cmdDataa = 32'h0000_000a; cmdDatab = 32'h0000_000b;
        @(negedge clock);
        cmdValidA = 1'b0;
        @(negedge clock);
        ciReady = 1'b1; ciResult = 32'h5a5a_0001;
        @(negedge clock);
        ciReady = 1'b0;
        checks++; if (aRspValid !== 1'b1) begin errors++; $display("[TB] FAIL t5_rsp_valid got %b want 1", aRspValid); end
        cmdValidA = 1'b1; cmdSelectN = 8'd4; cmdDataa = 32'h0000_0044; cmdDatab = 32'h0000_0055;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            checks++;
            if ({aCmdReady, aRspValid, aRspResult, aRspSelectN, aCiDataa} !== {2'b01, 32'h5a5a_0001, 8'd3, 32'h0000_000a}) begin
                errors++;
                $display("[TB] FAIL t5_hold_cycle%0d got %h want %h", i, {aCmdReady, aRspValid, aRspResult, aRspSelectN, aCiDataa}, {2'b01, 32'h5a5a_0001, 8'd3, 32'h0000_000a});
            end
        end
        rspReadyA = 1'b1;
        @(negedge clock);
        rspReadyA = 1'b0;
        checks++; if ({aCmdReady, aTxnCount} !== {1'b1, 16'd3}) begin errors++; $display("[TB] FAIL t5_release got %h want %h", {aCmdReady, aTxnCount}, {1'b1, 16'd3}); end
        @(negedge clock);
        cmdValidA = 1'b0;
        checks++; if ({aCiStart, aCiSelectN, aCiDataa} !== {1'b1, 8'd4, 32'h0000_0044}) begin errors++; $display("[TB] FAIL t5_next_accept got %h want %h", {aCiStart, aCiSelectN, aCiDataa}, {1'b1, 8'd4, 32'h0000_0044}); end
        @(negedge clock);
        ciReady = 1'b1; ciResult = 32'd7;
        @(negedge clock);
        ciReady = 1'b0;
        checks++; if ({aRspValid, aRspResult, aRspSelectN} !== {1'b1, 32'd7, 8'd4}) begin errors++; $display("[TB] FAIL t5_next_rsp got %h want %h", {aRspValid, aRspResult, aRspSelectN}, {1'b1, 32'd7, 8'd4}); end
        rspReadyA = 1'b1;
        @(negedge clock);
        rspReadyA = 1'b0;
        checks++; if (aTxnCount !== 16'd4) begin errors++; $display("[TB] FAIL t5_txn_count got %0d want 4", aTxnCount); end
    endtask

    task automatic test_back_to_back;
        int nStarts;
        nStarts = 0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        cmdValidA = 1'b1; rspReadyA = 1'b1; ciReady = 1'b1;
        cmdSelectN = 8'd2; cmdDataa = 32'd0; cmdDatab = 32'd0; ciResult = 32'h0000_0042;
        for (int cyc = 0; cyc <= 16; cyc++) begin
            if (cyc > 0) @(negedge clock);
            if (aCiStart === 1'b1) begin
                checks++;
                if (cyc !== 1 + 4 * nStarts) begin errors++; $display("[TB] FAIL b2b_start%0d got cycle %0d want %0d", nStarts, cyc, 1 + 4 * nStarts); end
                nStarts++;
            end
            if (cyc == 13) cmdValidA = 1'b0;
        end
        rspReadyA = 1'b0; ciReady = 1'b0;
        checks++; if (nStarts !== 4) begin errors++; $display("[TB] FAIL b2b_start_count got %0d want 4", nStarts); end
        checks++; if ({aTxnCount, aRspResult} !== {16'd4, 32'h0000_0042}) begin errors++; $display("[TB] FAIL b2b_txn_count got %h want %h", {aTxnCount, aRspResult}, {16'd4, 32'h0000_0042}); end
    endtask

    task automatic test_reset_mid;
        @(negedge clock);
        cmdValidA = 1'b1; cmdSelectN = 8'd1; cmdDataa = 32'd9; cmdDatab = 32'd9; ciReady = 1'b0;
        @(negedge clock);
        cmdValidA = 1'b0;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        checks++; if (aBusy !== 1'b1) begin errors++; $display("[TB] FAIL t6_busy_wait3 got %b want 1", aBusy); end
        reset = 1'b1;
        #1;
        checks++; if ({aCiReset, aRspValid, aBusy} !== 3'b100) begin errors++; $display("[TB] FAIL t6_async_reset got %b want 100", {aCiReset, aRspValid, aBusy}); end
        checks++; if ({aTxnCount, aCiDataa} !== 48'd0) begin errors++; $display("[TB] FAIL t6_cleared got %h want 0", {aTxnCount, aCiDataa}); end
        @(negedge clock);
        checks++; if (aCiReset !== 1'b1) begin errors++; $display("[TB] FAIL t6_ci_reset_held got %b want 1", aCiReset); end
        reset = 1'b0;
        #1;
        checks++; if ({aCiReset, aCmdReady} !== 2'b01) begin errors++; $display("[TB] FAIL t6_release got %b want 01", {aCiReset, aCmdReady}); end
        @(negedge clock);
        cmdValidA = 1'b1; cmdSelectN = 8'd1; cmdDataa = 32'd5; cmdDatab = 32'd0;
        @(negedge clock);
        cmdValidA = 1'b0;
        checks++; if (aCiStart !== 1'b1) begin errors++; $display("[TB] FAIL t6_restart got %b want 1", aCiStart); end
        @(negedge clock);
        ciReady = 1'b1; ciResult = 32'h0000_00aa;
        @(negedge clock);
        ciReady = 1'b0;
        checks++; if ({aRspValid, aRspResult, aRspTimeout} !== {1'b1, 32'h0000_00aa, 1'b0}) begin errors++; $display("[TB] FAIL t6_rsp got %h want %h", {aRspValid, aRspResult, aRspTimeout}, {1'b1, 32'h0000_00aa, 1'b0}); end
        rspReadyA = 1'b1;
        @(negedge clock);
        rspReadyA = 1'b0;
        checks++; if (aTxnCount !== 16'd1) begin errors++; $display("[TB] FAIL t6_txn_count got %0d want 1", aTxnCount); end
    endtask

    initial begin
        reset = 1'b1;
        cmdValidA = 1'b0; cmdValidB = 1'b0;
        cmdSelectN = 8'd0; cmdDataa = 32'd0; cmdDatab = 32'd0;
        ciResult = 32'd0; ciReady = 1'b0;
        rspReadyA = 1'b0; rspReadyB = 1'b0;
        test_reset();
        test_single();
        test_wait_hold();
        test_timeout();
        test_ready_at_expiry();
        test_held_response();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
